// File: rtl/fpga_slave_pkg.sv
// fpga_slave_pkg: shared FSM states, PWM_Q encodings and timing defaults for the discharge sequencer
package fpga_slave_pkg;
    typedef enum logic [1:0] {ST_IDLE, ST_PRECHARGE, ST_TON, ST_TOFF} dpg_state_t;
    typedef enum logic [1:0] {Q_OFF = 2'b00, Q_DISCH = 2'b01, Q_FREEWHEEL = 2'b10} pwm_q_t;
    localparam int TICKS_PER_US_DEF      = 100;
    localparam int BUCK_PERIOD_DEF       = 400;
    localparam int DEADTIME_DEF          = 20;
    localparam int PRECHARGE_PERIODS_DEF = 4;
    function automatic logic [15:0] clamp16(input logic [15:0] v, input logic [15:0] lim);
        return v > lim ? lim : v;
    endfunction
endpackage

// File: rtl/buck_phase_gate.sv
// buck_phase_gate: registered high/low-side gate pair for one interleaved buck phase
module buck_phase_gate import fpga_slave_pkg::*; #(
    parameter int BUCK_PERIOD = BUCK_PERIOD_DEF,
    parameter int DEADTIME    = DEADTIME_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] t,
    input  logic [15:0] chg,
    input  logic        en,
    output logic        hi,
    output logic        lo
);
    logic [16:0] lo_start;
    assign lo_start = {1'b0, chg} + 17'(DEADTIME);
    always_ff @(posedge clk) begin
        if (rst) begin
            hi <= 1'b0;
            lo <= 1'b0;
        end else begin
            hi <= en && t < chg;
            lo <= en && {1'b0, t} >= lo_start && t < 16'(BUCK_PERIOD - DEADTIME);
        end
    end
endmodule

// File: rtl/discharge_pulse_gen.sv
// discharge_pulse_gen: discharge pulse sequencer driving a 4-phase interleaved buck and the gap switches
module discharge_pulse_gen import fpga_slave_pkg::*; #(
    parameter int TICKS_PER_US      = TICKS_PER_US_DEF,
    parameter int BUCK_PERIOD       = BUCK_PERIOD_DEF,
    parameter int DEADTIME          = DEADTIME_DEF,
    parameter int PRECHARGE_PERIODS = PRECHARGE_PERIODS_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        is_machine,
    input  logic [15:0] Ton_data,
    input  logic [15:0] Toff_data,
    input  logic [15:0] Ip_data,
    input  logic [15:0] inductor_charging_time,
    output logic [15:0] timer_buck_4us_0,
    output logic [15:0] i_set,
    output logic [7:0]  PWM,
    output logic [1:0]  PWM_Q,
    output logic        pulse_active
);
    localparam logic [15:0] CHG_MAX   = 16'(BUCK_PERIOD - 2 * DEADTIME);
    localparam logic [15:0] LAST_TICK = 16'(BUCK_PERIOD - 1);
    localparam logic [31:0] PRE_LEN   = 32'(PRECHARGE_PERIODS * BUCK_PERIOD);

    dpg_state_t  state, state_nxt;
    pwm_q_t      q_nxt;
    logic [15:0] timer, timer_nxt, chg, chg_nxt;
    logic [31:0] cnt, cnt_nxt, ton_t, toff_t;
    logic        wrap, params_ok, relatch, en_nxt;

    assign wrap             = timer == LAST_TICK;
    assign timer_nxt        = wrap ? '0 : timer + 16'd1;
    assign chg_nxt          = wrap ? clamp16(inductor_charging_time, CHG_MAX) : chg;
    assign params_ok        = is_machine && Ton_data != '0 && Toff_data != '0;
    assign en_nxt           = state_nxt == ST_PRECHARGE || state_nxt == ST_TON;
    assign cnt_nxt          = state_nxt != state ? '0 : cnt + 32'd1;
    assign timer_buck_4us_0 = timer;

    always_comb begin
        state_nxt = state;
        relatch   = 1'b0;
        unique case (state)
            ST_IDLE: if (params_ok && wrap) begin
                state_nxt = ST_PRECHARGE;
                relatch   = 1'b1;
            end
            ST_PRECHARGE: if (cnt == PRE_LEN - 32'd1) state_nxt = ST_TON;
            ST_TON: if (cnt == ton_t - 32'd1) state_nxt = ST_TOFF;
            ST_TOFF: if (cnt >= toff_t - 32'd1) begin
                if (!params_ok) state_nxt = ST_IDLE;
                else if (wrap) begin
                    state_nxt = ST_PRECHARGE;
                    relatch   = 1'b1;
                end
            end
        endcase
        if (!is_machine) state_nxt = ST_IDLE;
    end

    // entering TON or TOFF spends one cycle with both gap switches open
    assign q_nxt = state_nxt == ST_PRECHARGE ? Q_FREEWHEEL :
                   state_nxt != state        ? Q_OFF :
                   state == ST_TON           ? Q_DISCH :
                   state == ST_TOFF          ? Q_FREEWHEEL : Q_OFF;

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_IDLE;
            timer        <= '0;
            chg          <= '0;
            cnt          <= '0;
            ton_t        <= '0;
            toff_t       <= '0;
            i_set        <= '0;
            PWM_Q        <= Q_OFF;
            pulse_active <= 1'b0;
        end else begin
            state        <= state_nxt;
            timer        <= timer_nxt;
            chg          <= chg_nxt;
            cnt          <= cnt_nxt;
            i_set        <= state_nxt == ST_IDLE ? '0 : relatch ? Ip_data : i_set;
            PWM_Q        <= q_nxt;
            pulse_active <= en_nxt;
            if (relatch) begin
                ton_t  <= 32'(Ton_data) * 32'(TICKS_PER_US);
                toff_t <= 32'(Toff_data) * 32'(TICKS_PER_US);
            end
        end
    end

    for (genvar g = 0; g < 4; g++) begin : g_phase
        logic [15:0] sum, t;
        assign sum = timer_nxt + 16'(BUCK_PERIOD - g * BUCK_PERIOD / 4);
        assign t   = sum >= 16'(BUCK_PERIOD) ? sum - 16'(BUCK_PERIOD) : sum;
        buck_phase_gate #(
            .BUCK_PERIOD(BUCK_PERIOD),
            .DEADTIME(DEADTIME)
        ) u_gate (
            .clk(clk),
            .rst(rst),
            .t(t),
            .chg(chg_nxt),
            .en(en_nxt),
            .hi(PWM[2*g]),
            .lo(PWM[2*g+1])
        );
    end
endmodule

// File: tb/tb_discharge_pulse_gen.sv
// tb_discharge_pulse_gen: directed and randomized checks against a schedule-based reference model
module tb_discharge_pulse_gen;
    logic        clk = 1'b0;
    logic        rst, is_machine;
    logic [15:0] ton_d, toff_d, ip_d, ict;
    logic [15:0] timer, i_set;
    logic [7:0]  pwm;
    logic [1:0]  pwm_q;
    logic        pulse_active;
    int          checks = 0, passes = 0, clk_count = 0;

    always #5 clk = ~clk;
    always @(posedge clk) clk_count <= clk_count + 1;

    discharge_pulse_gen dut (
        .clk(clk),
        .rst(rst),
        .is_machine(is_machine),
        .Ton_data(ton_d),
        .Toff_data(toff_d),
        .Ip_data(ip_d),
        .inductor_charging_time(ict),
        .timer_buck_4us_0(timer),
        .i_set(i_set),
        .PWM(pwm),
        .PWM_Q(pwm_q),
        .pulse_active(pulse_active)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, exp, $time);
    endtask

    function automatic int probe(input int sel);
        return sel == 0 ? int'(pulse_active) : sel == 1 ? int'(pwm_q) : int'(timer);
    endfunction

    task automatic wait_for(input string name, input int sel, input int val, input int lim, output int cyc);
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (probe(sel) != val && cyc < lim);
        if (probe(sel) != val) begin
            checks++;
            $display("FAIL %s: no match within %0d cycles, got %0d required %0d", name, lim, probe(sel), val);
        end
    endtask

    // Reference model: cycle index n since reset; a pulse is a schedule of absolute cycle numbers.
    int          n = 0, ton_start = 0, toff_start = 0, toff_end = 0;
    int          m_t, m_st, m_tk;
    bit          m_valid = 0, armed = 0, m_ok;
    logic [15:0] m_chg = '0, p_ip = '0, e_is;
    logic [7:0]  e_pwm;
    logic [1:0]  e_q;
    logic        e_pa, ov;

    initial begin
        forever begin
            @(posedge clk);
            if (rst) begin
                n = 0;
                m_valid = 0;
                m_chg = '0;
                armed = 1;
            end else begin
                n++;
                if (n % 400 == 0) m_chg = ict > 16'd360 ? 16'd360 : ict;
                m_ok = is_machine && ton_d != 0 && toff_d != 0;
                if (!is_machine) m_valid = 0;
                else if (m_valid && n >= toff_end && !m_ok) m_valid = 0;
                else if ((!m_valid || n >= toff_end) && m_ok && n % 400 == 0) begin
                    m_valid = 1;
                    ton_start = n + 1600;
                    toff_start = ton_start + int'(ton_d) * 100;
                    toff_end = toff_start + int'(toff_d) * 100;
                    p_ip = ip_d;
                end
            end
            @(negedge clk);
            if (armed) begin
                m_t = n % 400;
                m_st = !m_valid ? 0 : n < ton_start ? 1 : n < toff_start ? 2 : 3;
                e_q = m_st == 1 ? 2'b10 : m_st == 2 ? (n == ton_start ? 2'b00 : 2'b01) :
                      m_st == 3 ? (n == toff_start ? 2'b00 : 2'b10) : 2'b00;
                e_pa = m_st == 1 || m_st == 2;
                e_is = m_valid ? p_ip : 16'd0;
                e_pwm = '0;
                for (int k = 0; k < 4; k++) begin
                    m_tk = (m_t + 400 - 100 * k) % 400;
                    if (e_pa) begin
                        e_pwm[2*k]   = m_tk < m_chg;
                        e_pwm[2*k+1] = m_tk >= m_chg + 20 && m_tk < 380;
                    end
                end
                check("outputs", {timer, pwm, pwm_q, i_set, pulse_active}, {16'(m_t), e_pwm, e_q, e_is, e_pa});
                ov = (pwm[0] & pwm[1]) | (pwm[2] & pwm[3]) | (pwm[4] & pwm[5]) | (pwm[6] & pwm[7]);
                check("gate_overlap", ov, 0);
                check("pwm_q_11", pwm_q == 2'b11, 0);
            end
        end
    end

    initial begin
        int c, mark;
        rst = 1; is_machine = 0; ton_d = 0; toff_d = 0; ip_d = 0; ict = 0;
        repeat (3) @(negedge clk);
        check("reset_state", {timer, pwm, pwm_q, i_set, pulse_active}, 0);
        rst = 0;
        ton_d = 5; toff_d = 10; ip_d = 1000; ict = 150; is_machine = 1;
        wait_for("first_pulse", 0, 1, 450, c);
        check("start_latency", c <= 400, 1);
        mark = clk_count;
        check("pre_entry", {timer, pwm_q, i_set}, {16'd0, 2'b10, 16'd1000});
        check("interleave_t0", pwm, 8'h69);
        wait_for("t150", 2, 150, 400, c);
        check("interleave_t150", pwm, 8'hA4);
        wait_for("t170", 2, 170, 400, c);
        check("interleave_t170", pwm, 8'hA6);
        wait_for("ton_start", 1, 0, 2000, c);
        check("precharge_len", clk_count - mark, 1600);
        check("ton_entry", {timer, pwm, pulse_active}, {16'd0, 8'h69, 1'b1});
        mark = clk_count;
        wait_for("ton_disch", 1, 1, 3, c);
        check("break_before_make", c, 1);
        ip_d = 2000;
        wait_for("toff_start", 1, 0, 600, c);
        check("ton_len", clk_count - mark, 500);
        check("toff_entry", {pwm, pulse_active, i_set}, {8'h00, 1'b0, 16'd1000});
        mark = clk_count;
        wait_for("second_pulse", 0, 1, 1500, c);
        check("toff_to_pre_len", clk_count - mark, 1100);
        check("ip_relatch", {timer, i_set}, {16'd0, 16'd2000});
        ict = 500;
        wait_for("clamp_period", 2, 0, 401, c);
        check("clamp_t0", {pulse_active, pwm}, {1'b1, 8'h55});
        wait_for("clamp_t359", 2, 359, 400, c);
        check("clamp_t359", pwm, 8'h55);
        wait_for("clamp_t360", 2, 360, 400, c);
        check("clamp_t360", pwm, 8'h54);
        wait_for("clamp_t399", 2, 399, 400, c);
        check("clamp_deadtime", pwm, 8'h54);
        ict = 150;
        wait_for("abort_ton", 1, 1, 1300, c);
        is_machine = 0;
        @(negedge clk);
        check("abort", {pwm, pwm_q, i_set, pulse_active}, 0);
        is_machine = 1;
        wait_for("restart", 0, 1, 450, c);
        repeat (200) @(negedge clk);
        rst = 1;
        @(negedge clk);
        check("reset_mid_pre", {timer, pwm, pwm_q, i_set, pulse_active}, 0);
        rst = 0;
        ton_d = 0;
        c = 0;
        repeat (900) begin
            @(negedge clk);
            c += int'(pulse_active) + int'(pwm_q != 2'b00);
        end
        check("ton_zero_idle", c, 0);
        ton_d = 3; toff_d = 0;
        c = 0;
        repeat (900) begin
            @(negedge clk);
            c += int'(pulse_active) + int'(pwm_q != 2'b00);
        end
        check("toff_zero_idle", c, 0);
        for (int i = 0; i < 40; i++) begin
            ton_d = 16'($urandom_range(0, 4));
            toff_d = 16'($urandom_range(0, 4));
            ip_d = 16'($urandom);
            ict = $urandom_range(0, 3) == 0 ? 16'd0 : 16'($urandom_range(1, 450));
            is_machine = $urandom_range(0, 9) != 0;
            if ($urandom_range(0, 19) == 0) rst = 1;
            @(negedge clk);
            rst = 0;
            repeat ($urandom_range(50, 900)) @(negedge clk);
        end
        repeat (5) @(negedge clk);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule

// File: doc/discharge_pulse_gen.md
# discharge_pulse_gen

Discharge pulse sequencer and 4-phase interleaved buck PWM driver. Consumes `is_machine`, `Ton_data`, `Toff_data` and `Ip_data` from `parameter_generator`, and `inductor_charging_time` from `one_cycle_control`. Produces the `timer_buck_4us_0` and `i_set` inputs that `one_cycle_control` needs, and drives the board `PWM[7:0]` / `PWM_Q[1:0]` pins. Runs entirely in the 100 MHz domain.

## Interface
- `TICKS_PER_US`, 100: clk cycles per µs.
- `BUCK_PERIOD`, 400: buck switching period in cycles (4 µs).
- `DEADTIME`, 20: high/low-side dead time in cycles.
- `PRECHARGE_PERIODS`, 4: buck periods of inductor precharge before each Ton.
- `clk` in 1: 100 MHz system clock.
- `rst` in 1: synchronous, active-high reset.
- `is_machine` in 1: machining enable, level.
- `Ton_data` in 16: discharge on-time in µs.
- `Toff_data` in 16: discharge off-time in µs.
- `Ip_data` in 16: peak current setpoint, in ADC codes.
- `inductor_charging_time` in 16: requested high-side on-time per buck period, in cycles.
- `timer_buck_4us_0` out 16: free-running buck phase-0 timer, 0..BUCK_PERIOD-1.
- `i_set` out 16: current setpoint latched for the active pulse.
- `PWM` out 8: buck gates. `PWM[2k]` is the high side and `PWM[2k+1]` the low side of phase k, for k=0..3.
- `PWM_Q` out 2: bit0 is the gap discharge switch; bit1 is the freewheel/bypass switch.
- `pulse_active` out 1: high in PRECHARGE and TON.

## Operation
- Timer:
  - `timer_buck_4us_0` counts 0..BUCK_PERIOD-1 and wraps.
  - It runs in all states, including IDLE; only `rst` clears it.
- Charge-time latch:
  - At `timer==BUCK_PERIOD-1`, `chg` ← min(`inductor_charging_time`, BUCK_PERIOD−2·DEADTIME).
  - `chg` is constant for the whole buck period.
- Phase offset: phase k uses `t_k = (timer + BUCK_PERIOD − k·BUCK_PERIOD/4) mod BUCK_PERIOD`.
- Gate rules while buck is enabled:
  - High side is on when `t_k < chg`.
  - Low side is on when `chg+DEADTIME ≤ t_k < BUCK_PERIOD−DEADTIME`.
  - `chg==0` gives high side permanently off, with the low side still following the rule.
- Buck enable: only in PRECHARGE and TON. Otherwise `PWM` = 0.
- FSM states:
  - **IDLE**
    - Outputs: `PWM=0`, `PWM_Q=2'b00`, `i_set=0`.
    - Leaves when `is_machine`=1, `Ton_data`≠0 and `Toff_data`≠0.
    - On leaving, latch `ton_t = Ton_data·TICKS_PER_US`, `toff_t = Toff_data·TICKS_PER_US` (32-bit products) and `i_set ← Ip_data`.
    - Next state: PRECHARGE, entered at the next `timer==0`.
  - **PRECHARGE**
    - Outputs: `PWM_Q=2'b10`.
    - Lasts PRECHARGE_PERIODS full buck periods, then goes to TON.
  - **TON**
    - Outputs: `PWM_Q=2'b01`.
    - Lasts `ton_t` cycles, then goes to TOFF.
  - **TOFF**
    - Outputs: `PWM=0`, `PWM_Q=2'b10`, `i_set` held.
    - Lasts `toff_t` cycles.
    - Then re-latches `Ton`/`Toff`/`Ip` and returns to PRECHARGE at the next `timer==0`, provided the IDLE entry conditions still hold; otherwise goes to IDLE.
- Abort: `is_machine`=0 in any state goes to IDLE on the next cycle, with all gates off on that same edge.
- Parameter changes mid-pulse have no effect until the next re-latch.

## Timing
- Every output is registered. State entry is visible on the outputs on the same clock edge as the state register update.
- Reset values: `timer=0`, `i_set=0`, `PWM=0`, `PWM_Q=0`, `pulse_active=0`, state IDLE.
- The `PWM_Q` switch between 2'b10 and 2'b01 passes through one 2'b00 cycle (break-before-make). That cycle counts toward the new state's duration.
- Start latency: IDLE exit to the first PRECHARGE gate is ≤ BUCK_PERIOD cycles, for alignment to `timer==0`.
- No cycle ever has `PWM[2k]` and `PWM[2k+1]` both high.
- No cycle ever has `PWM_Q=2'b11`.

## Structure
- Shared package `fpga_slave_pkg` holds:
  - the FSM state enum (`ST_IDLE`, `ST_PRECHARGE`, `ST_TON`, `ST_TOFF`);
  - the `PWM_Q` encodings (`Q_OFF`, `Q_DISCH`, `Q_FREEWHEEL`);
  - the default timing constants.
- One sub-module, `buck_phase_gate`, is instantiated 4×. It takes `t_k`, `chg`, `en` and `DEADTIME`, and outputs the registered high/low gate pair.

## Test plan
- Nominal pulse train:
  - Stimulus: `Ton=5`, `Toff=10`, `Ip=1000`, `inductor_charging_time=150`, `is_machine`=1.
  - Required: `i_set=1000`; PRECHARGE lasts 1600 cycles; `PWM_Q=01` for 500 cycles; `PWM_Q=10` for 1000 cycles; the sequence repeats.
- Phase interleave:
  - Stimulus: `chg=150`.
  - Required: high-side rising edges of phases 0..3 at timer 0/100/200/300; each high pulse is 150 cycles wide; the low side rises 20 cycles after the high side falls.
- Clamp:
  - Stimulus: `inductor_charging_time=500`.
  - Required: high pulse is 360 cycles; low side is never on; 20 cycles of dead time before the wrap.
- Abort mid-TON:
  - Stimulus: `is_machine`→0.
  - Required: `PWM=0`, `PWM_Q=00` and `i_set=0` on the next edge; `rst` mid-PRECHARGE gives the same result.
- Invalid and updated parameters:
  - Stimulus: `Ton=0`.
  - Required: stays IDLE.
  - Stimulus: `Ip` changed during TON.
  - Required: `i_set` changes only at the following TOFF→PRECHARGE transition.
- Invariants, checked throughout all scenarios:
  - no complementary gate overlap;
  - no `PWM_Q=11`;
  - timer wraps 399→0.
